// File: rtl/cabac_mvd_debin.sv
// MVD debinarizer: walks greater0/greater1/EG1/sign/mvp bins from the CABAC
// decoder and rebuilds signed mvd_x/mvd_y and the mvp flag for one list.
module cabac_mvd_debin #(
  parameter int MVD_WIDTH     = 11,
  parameter int EG_MAX_PREFIX = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  output logic                 bin_req_o,
  output logic [1:0]           bin_ctx_o,
  output logic                 bin_bypass_o,
  input  logic                 bin_valid_i,
  input  logic                 bin_i,
  output logic [MVD_WIDTH-1:0] mvd_x_o,
  output logic [MVD_WIDTH-1:0] mvd_y_o,
  output logic                 mvp_idx_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 busy_o
);

  // Accumulator holds up to 2 + (2^(P+1)-2) + (2^(P+1)-1) and must also hold the limit.
  localparam int ACC_W = (EG_MAX_PREFIX + 3 > MVD_WIDTH + 1) ? EG_MAX_PREFIX + 3 : MVD_WIDTH + 1;
  localparam int K_W   = $clog2(EG_MAX_PREFIX + 2) + 1;
  localparam logic [ACC_W-1:0]     MAG_LIM = ACC_W'(1) << (MVD_WIDTH - 1);
  localparam logic [MVD_WIDTH-1:0] SAT_POS = {1'b0, {(MVD_WIDTH-1){1'b1}}};
  localparam logic [K_W-1:0]       K_OVF   = K_W'(EG_MAX_PREFIX + 1);

  typedef enum logic [3:0] {
    IDLE, G0X, G0Y, G1X, G1Y, EGX_PRE, EGX_SUF, SGNX,
    EGY_PRE, EGY_SUF, SGNY, MVP, DONE
  } state_t;

  state_t state_reg, state_next;

  logic             g0x_reg, g0y_reg, g1x_reg, g1y_reg;
  logic             sign_x_reg, sign_y_reg;
  logic [ACC_W-1:0] acc_reg, mag_x_reg, mag_y_reg;
  logic [K_W-1:0]   k_reg, cnt_reg;
  logic [MVD_WIDTH-1:0] mvd_x_reg, mvd_y_reg;
  logic             mvp_reg, err_reg;

  logic             take;
  logic             prefix_ovf;
  logic [ACC_W-1:0] acc_sum, eg_abs;

  assign take       = bin_req_o & bin_valid_i;
  assign prefix_ovf = bin_i && (k_reg == K_OVF);
  assign acc_sum    = acc_reg + (bin_i ? (ACC_W'(1) << (cnt_reg - K_W'(1))) : '0);
  assign eg_abs     = acc_sum + ACC_W'(2);

  function automatic logic [MVD_WIDTH-1:0] signed_mag(input logic [ACC_W-1:0] mag,
                                                      input logic sign);
    logic [MVD_WIDTH-1:0] m;
    m = (mag > MAG_LIM) ? SAT_POS : mag[MVD_WIDTH-1:0];
    return sign ? -m : m;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_i) state_next = G0X;
      G0X:     if (take) state_next = G0Y;
      G0Y:     if (take) state_next = g0x_reg ? G1X : (bin_i ? G1Y : MVP);
      G1X:     if (take) state_next = g0y_reg ? G1Y : (bin_i ? EGX_PRE : SGNX);
      G1Y:     if (take) state_next = g0x_reg ? (g1x_reg ? EGX_PRE : SGNX)
                                              : (bin_i ? EGY_PRE : SGNY);
      EGX_PRE: if (take) state_next = bin_i ? (prefix_ovf ? DONE : EGX_PRE) : EGX_SUF;
      EGX_SUF: if (take && cnt_reg == K_W'(1)) state_next = SGNX;
      SGNX:    if (take) state_next = g0y_reg ? (g1y_reg ? EGY_PRE : SGNY) : MVP;
      EGY_PRE: if (take) state_next = bin_i ? (prefix_ovf ? DONE : EGY_PRE) : EGY_SUF;
      EGY_SUF: if (take && cnt_reg == K_W'(1)) state_next = SGNY;
      SGNY:    if (take) state_next = MVP;
      MVP:     if (take) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bin_req_o    = (state_reg != IDLE) && (state_reg != DONE);
    bin_bypass_o = 1'b0;
    bin_ctx_o    = 2'd0;
    case (state_reg)
      G1X, G1Y: bin_ctx_o = 2'd1;
      MVP:      bin_ctx_o = 2'd2;
      EGX_PRE, EGX_SUF, SGNX, EGY_PRE, EGY_SUF, SGNY: bin_bypass_o = 1'b1;
      default:  bin_ctx_o = 2'd0;
    endcase
    done_o = (state_reg == DONE);
    busy_o = (state_reg != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {g0x_reg, g0y_reg, g1x_reg, g1y_reg, sign_x_reg, sign_y_reg} <= '0;
      acc_reg   <= '0;
      mag_x_reg <= '0;
      mag_y_reg <= '0;
      k_reg     <= '0;
      cnt_reg   <= '0;
      mvd_x_reg <= '0;
      mvd_y_reg <= '0;
      mvp_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else if (state_reg == IDLE && start_i) begin
      {g0x_reg, g0y_reg, g1x_reg, g1y_reg, sign_x_reg, sign_y_reg} <= '0;
      acc_reg   <= '0;
      mag_x_reg <= '0;
      mag_y_reg <= '0;
      k_reg     <= K_W'(1);
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else if (take) begin
      case (state_reg)
        G0X: g0x_reg <= bin_i;
        G0Y: g0y_reg <= bin_i;
        G1X: begin
          g1x_reg   <= bin_i;
          mag_x_reg <= bin_i ? '0 : ACC_W'(1);
        end
        G1Y: begin
          g1y_reg   <= bin_i;
          mag_y_reg <= bin_i ? '0 : ACC_W'(1);
        end
        EGX_PRE, EGY_PRE: begin
          if (!bin_i) begin
            cnt_reg <= k_reg;
          end else if (prefix_ovf) begin
            // Abandon the syntax element: report zero vectors with the error.
            err_reg   <= 1'b1;
            mvd_x_reg <= '0;
            mvd_y_reg <= '0;
            mvp_reg   <= 1'b0;
          end else begin
            acc_reg <= acc_reg + (ACC_W'(1) << k_reg);
            k_reg   <= k_reg + K_W'(1);
          end
        end
        EGX_SUF, EGY_SUF: begin
          cnt_reg <= cnt_reg - K_W'(1);
          acc_reg <= acc_sum;
          if (cnt_reg == K_W'(1)) begin
            if (state_reg == EGX_SUF) mag_x_reg <= eg_abs;
            else                      mag_y_reg <= eg_abs;
            acc_reg <= '0;
            k_reg   <= K_W'(1);
            if (eg_abs > MAG_LIM) err_reg <= 1'b1;
          end
        end
        SGNX: sign_x_reg <= bin_i;
        SGNY: sign_y_reg <= bin_i;
        MVP: begin
          mvp_reg   <= bin_i;
          mvd_x_reg <= signed_mag(mag_x_reg, sign_x_reg);
          mvd_y_reg <= signed_mag(mag_y_reg, sign_y_reg);
        end
        default: ;
      endcase
    end
  end

  assign mvd_x_o   = mvd_x_reg;
  assign mvd_y_o   = mvd_y_reg;
  assign mvp_idx_o = mvp_reg;
  assign err_o     = err_reg;

endmodule

// File: tb/tb_cabac_mvd_debin.sv
// Bench for cabac_mvd_debin: an encoder-side model turns target MVDs into
// bin/context sequences, feeds them and checks the reconstructed result.
module tb_cabac_mvd_debin;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        bin_req_o;
  logic [1:0]  bin_ctx_o;
  logic        bin_bypass_o;
  logic        bin_valid_i;
  logic        bin_i;
  logic [10:0] mvd_x_o;
  logic [10:0] mvd_y_o;
  logic        mvp_idx_o;
  logic        done_o;
  logic        err_o;
  logic        busy_o;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected bin stream; ctx code 3 stands for a bypass bin.
  bit          exp_bin[$];
  int          exp_ctx[$];
  logic [10:0] e_x, e_y;
  logic        e_mvp, e_err;

  cabac_mvd_debin #(.MVD_WIDTH(11), .EG_MAX_PREFIX(10)) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .bin_req_o(bin_req_o), .bin_ctx_o(bin_ctx_o), .bin_bypass_o(bin_bypass_o),
    .bin_valid_i(bin_valid_i), .bin_i(bin_i),
    .mvd_x_o(mvd_x_o), .mvd_y_o(mvd_y_o), .mvp_idx_o(mvp_idx_o),
    .done_o(done_o), .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic void push(input bit b, input int c);
    exp_bin.push_back(b);
    exp_ctx.push_back(c);
  endfunction

  function automatic void push_eg1(input int value);
    int v = value;
    int k = 1;
    while (v >= (1 << k)) begin
      push(1'b1, 3);
      v -= (1 << k);
      k++;
    end
    push(1'b0, 3);
    for (int i = k - 1; i >= 0; i--) push(bit'((v >> i) & 1), 3);
  endfunction

  function automatic logic [10:0] expect_mvd(input int a, input bit s);
    int v = (a > 1024) ? 1023 : a;
    if (s) v = -v;
    return 11'(v);
  endfunction

  task automatic build_case(input int ax, input bit sx, input int ay, input bit sy, input bit mvp);
    exp_bin.delete();
    exp_ctx.delete();
    push(ax != 0, 0);
    push(ay != 0, 0);
    if (ax != 0) push(ax > 1, 1);
    if (ay != 0) push(ay > 1, 1);
    if (ax != 0) begin
      if (ax > 1) push_eg1(ax - 2);
      push(sx, 3);
    end
    if (ay != 0) begin
      if (ay > 1) push_eg1(ay - 2);
      push(sy, 3);
    end
    push(mvp, 2);
    e_x   = expect_mvd(ax, sx);
    e_y   = expect_mvd(ay, sy);
    e_mvp = mvp;
    e_err = (ax > 1024) || (ay > 1024);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bin_valid_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // stall_mode 1 presents a bin only every third cycle; poke toggles start_i while busy.
  task automatic run_case(input string name, input bit stall_mode, input bit poke);
    int  idx = 0;
    int  cyc = 0;
    int  got_ctx;
    bit  seen = 1'b0;
    bit  aborted = 1'b0;
    bit  valid;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    while (cyc < 400) begin
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      bin_valid_i = 1'b0;
      if (bin_req_o) begin
        if (idx >= exp_bin.size()) begin
          n_cmp++; n_fail++;
          $display("FAIL %s extra_bin: requested bin %0d, required only %0d bins", name, idx, exp_bin.size());
          aborted = 1'b1;
          break;
        end
        got_ctx = bin_bypass_o ? 3 : int'(bin_ctx_o);
        n_cmp++;
        if (got_ctx !== exp_ctx[idx]) begin
          n_fail++;
          $display("FAIL %s ctx bin %0d: got %0d required %0d (3=bypass)", name, idx, got_ctx, exp_ctx[idx]);
        end
        valid = !stall_mode || (cyc % 3 == 2);
        bin_i = exp_bin[idx];
        bin_valid_i = valid;
        if (valid) idx++;
      end
      start_i = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      cyc++;
    end
    bin_valid_i = 1'b0;
    start_i = 1'b0;
    if (aborted || !seen) begin
      if (!seen) begin
        n_cmp++; n_fail++;
        $display("FAIL %s timeout: no done_o after %0d cycles, %0d bins taken", name, cyc, idx);
      end
      do_reset();
      return;
    end
    n_cmp++;
    if (idx != exp_bin.size()) begin
      n_fail++;
      $display("FAIL %s bin_count: got %0d required %0d", name, idx, exp_bin.size());
    end
    if (!stall_mode) begin
      n_cmp++;
      if (cyc != exp_bin.size()) begin
        n_fail++;
        $display("FAIL %s latency: done after %0d cycles required %0d", name, cyc, exp_bin.size());
      end
    end
    n_cmp++;
    if ({mvd_x_o, mvd_y_o, mvp_idx_o, err_o, busy_o} !== {e_x, e_y, e_mvp, e_err, 1'b1}) begin
      n_fail++;
      $display("FAIL %s result: got x=%h y=%h mvp=%b err=%b busy=%b required x=%h y=%h mvp=%b err=%b busy=1",
               name, mvd_x_o, mvd_y_o, mvp_idx_o, err_o, busy_o, e_x, e_y, e_mvp, e_err);
    end
    // A start in the DONE cycle must not be accepted.
    start_i = poke;
    @(negedge clk);
    start_i = 1'b0;
    n_cmp++;
    if ({done_o, busy_o, bin_req_o, mvd_x_o, mvd_y_o, mvp_idx_o, err_o} !==
        {1'b0, 1'b0, 1'b0, e_x, e_y, e_mvp, e_err}) begin
      n_fail++;
      $display("FAIL %s after_done: got done=%b busy=%b req=%b x=%h y=%h mvp=%b err=%b required 0,0,0 x=%h y=%h mvp=%b err=%b",
               name, done_o, busy_o, bin_req_o, mvd_x_o, mvd_y_o, mvp_idx_o, err_o, e_x, e_y, e_mvp, e_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_i = 1'b0;
    bin_valid_i = 1'b0;
    bin_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bin_req_o, bin_ctx_o, bin_bypass_o, mvd_x_o, mvd_y_o, mvp_idx_o, done_o, err_o, busy_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got req=%b ctx=%0d byp=%b x=%h y=%h mvp=%b done=%b err=%b busy=%b required all 0",
               bin_req_o, bin_ctx_o, bin_bypass_o, mvd_x_o, mvd_y_o, mvp_idx_o, done_o, err_o, busy_o);
    end
  endtask

  task automatic test_directed();
    build_case(0, 0, 0, 0, 1); run_case("zero_mvp1", 1'b0, 1'b0);
    build_case(1, 0, 1, 1, 0); run_case("one_minus_one", 1'b0, 1'b0);
    build_case(5, 0, 0, 0, 0); run_case("five_zero", 1'b0, 1'b0);
    build_case(2, 1, 1500, 0, 1); run_case("saturate_y", 1'b0, 1'b0);
  endtask

  task automatic test_prefix_overflow();
    exp_bin.delete();
    exp_ctx.delete();
    push(1, 0); push(0, 0); push(1, 1);
    for (int i = 0; i < 11; i++) push(1, 3);
    e_x = '0; e_y = '0; e_mvp = 1'b0; e_err = 1'b1;
    run_case("prefix_overflow", 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    build_case(1, 0, 1, 1, 0);
    run_case("backpressure", 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    build_case(5, 0, 0, 0, 0);
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bin_i = exp_bin[i];
      bin_valid_i = 1'b1;
      @(negedge clk);
    end
    bin_valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy_o, bin_req_o, done_o, err_o, mvd_x_o, mvd_y_o, mvp_idx_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b req=%b done=%b err=%b x=%h y=%h mvp=%b required all 0",
               busy_o, bin_req_o, done_o, err_o, mvd_x_o, mvd_y_o, mvp_idx_o);
    end
    rst = 1'b0;
    build_case(0, 0, 0, 0, 0);
    run_case("after_reset", 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int ax, ay;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       ax = $urandom_range(0, 3);
        1:       ax = $urandom_range(0, 60);
        2:       ax = $urandom_range(61, 1023);
        default: ax = $urandom_range(1025, 4000);
      endcase
      case ($urandom_range(0, 3))
        0:       ay = $urandom_range(0, 3);
        1:       ay = $urandom_range(0, 60);
        2:       ay = $urandom_range(61, 1023);
        default: ay = $urandom_range(1025, 4000);
      endcase
      build_case(ax, 1'($urandom_range(0, 1)), ay, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      run_case($sformatf("random_%0d", n), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_prefix_overflow();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
